// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - dual-read-port branch target buffer with 2-bit counters
//
// Purpose: direct-mapped BTB indexed by pc[IDX_W+1:2]. Two fetch slots are
// looked up combinationally every cycle. One resolved branch per cycle
// trains the table: a tag hit moves the saturating counter and refreshes the
// target on taken; a taken miss replaces the occupant; a not-taken miss is
// dropped.
//
// Configuration macro: BRANCH_PRED_EN
//   defined   - table and prediction logic are built
//   undefined - no storage; predictions tied to zero, upd_* ignored
//
// Ports:
//   clk                      clock, rising edge
//   rst                      asynchronous active-low reset
//   pc1, pc2                 lookup PCs for fetch slot 1/2 (word aligned)
//   pre_branch1/2            predicted taken for slot 1/2
//   predict_pc1/2            predicted target for slot 1/2 (0 if not taken)
//   upd_valid                a resolved branch is presented this cycle
//   upd_pc                   PC of the resolved branch
//   upd_taken                actual direction
//   upd_target               actual target

module branch_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc1,
  input  logic [31:0] pc2,
  output logic        pre_branch1,
  output logic        pre_branch2,
  output logic [31:0] predict_pc1,
  output logic [31:0] predict_pc2,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

`ifdef BRANCH_PRED_EN

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_q [N];
  logic             valid_d [N];
  logic [TAG_W-1:0] tag_q   [N];
  logic [TAG_W-1:0] tag_d   [N];
  logic [1:0]       cnt_q   [N];
  logic [1:0]       cnt_d   [N];
  logic [31:0]      tgt_q   [N];
  logic [31:0]      tgt_d   [N];

  logic [IDX_W-1:0] idx1, idx2, upd_idx;
  logic [TAG_W-1:0] tag1, tag2, upd_tag;
  logic             hit1, hit2, upd_hit;

  // Byte-offset bits of word-aligned PCs carry no information.
  logic unused_ok;
  assign unused_ok = ^{pc1[1:0], pc2[1:0], upd_pc[1:0]};

  assign idx1    = pc1[IDX_W+1:2];
  assign idx2    = pc2[IDX_W+1:2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign tag1    = pc1[31:IDX_W+2];
  assign tag2    = pc2[31:IDX_W+2];
  assign upd_tag = upd_pc[31:IDX_W+2];

  // Each slot compares its own tag even when both land on the same entry.
  assign hit1    = valid_q[idx1] && (tag_q[idx1] == tag1) && cnt_q[idx1][1];
  assign hit2    = valid_q[idx2] && (tag_q[idx2] == tag2) && cnt_q[idx2][1];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Reads come from the registered table, so a same-cycle update is not seen.
  assign pre_branch1 = rst & hit1;
  assign pre_branch2 = rst & hit2;
  assign predict_pc1 = pre_branch1 ? tgt_q[idx1] : 32'd0;
  assign predict_pc2 = pre_branch2 ? tgt_q[idx2] : 32'd0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      cnt_d[i]   = cnt_q[i];
      tgt_d[i]   = tgt_q[i];
    end
    if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          if (cnt_q[upd_idx] != 2'b11) cnt_d[upd_idx] = cnt_q[upd_idx] + 2'd1;
          tgt_d[upd_idx] = upd_target;
        end else begin
          if (cnt_q[upd_idx] != 2'b00) cnt_d[upd_idx] = cnt_q[upd_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Taken miss evicts whatever lives at this index; start weakly taken.
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        cnt_d[upd_idx]   = 2'b10;
        tgt_d[upd_idx]   = upd_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
        tgt_q[i]   <= 32'd0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        cnt_q[i]   <= cnt_d[i];
        tgt_q[i]   <= tgt_d[i];
      end
    end
  end

`else

  logic unused_ok;
  assign unused_ok = ^{clk, rst, pc1, pc2, upd_valid, upd_pc, upd_taken, upd_target};

  assign pre_branch1 = 1'b0;
  assign pre_branch2 = 1'b0;
  assign predict_pc1 = 32'd0;
  assign predict_pc2 = 32'd0;

`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, giving the BTB index width; the table holds 2^IDX_W entries.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports pc1, pc2  input  32  fetch-slot lookup PCs, word aligned.
REQ-005 SHALL have ports pre_branch1, pre_branch2  output  1  predicted taken for slot 1/2.
REQ-006 SHALL have ports predict_pc1, predict_pc2  output  32  predicted target for slot 1/2.
REQ-007 SHALL have port upd_valid  input  1  a resolved branch/jump is presented this cycle.
REQ-008 SHALL have port upd_pc  input  32  PC of the resolved instruction.
REQ-009 SHALL have port upd_taken  input  1  actual direction of the resolved instruction.
REQ-010 SHALL have port upd_target  input  32  actual target of the resolved instruction.

Function
REQ-011 SHALL store per entry: valid bit, tag = pc[31:IDX_W+2], 2-bit saturating counter, 32-bit target.
REQ-012 SHALL index both lookups and the update with pc[IDX_W+1:2]; both lookups SHALL be served every cycle (two read ports).
REQ-013 SHALL assert pre_branchN combinationally in the same cycle when the entry is valid, the tag matches pcN, and counter[1] = 1.
REQ-014 SHALL drive predict_pcN = the entry target on a hit, and 32'd0 when pre_branchN = 0.
REQ-015 SHALL compute slot 1 and slot 2 independently; slot priority is resolved by the fetch stage.
REQ-016 On upd_valid with a tag hit, SHALL increment the counter if upd_taken, saturating at 2'b11, else decrement it, saturating at 2'b00; if upd_taken, SHALL rewrite the target.
REQ-017 On upd_valid with a miss and upd_taken = 1, SHALL allocate the entry by replacing the occupant: valid = 1, tag from upd_pc, counter = 2'b10, target = upd_target.
REQ-018 On upd_valid with a miss and upd_taken = 0, SHALL leave the table unchanged.
REQ-019 SHALL make updates visible from the cycle after upd_valid; a same-cycle lookup of the updated index SHALL return pre-update contents.
REQ-020 SHALL leave state unchanged when upd_valid = 0; upd_* SHALL be don't-care in that case.
REQ-021 When pc1 and pc2 map to the same index, both slots SHALL read the same entry and each SHALL compare its own tag.

Reset
REQ-022 While rst = 0, SHALL clear all valid bits, set all counters to 2'b01 and all targets to 0, and force pre_branch1/2 = 0 and predict_pc1/2 = 0.
REQ-023 Reset asserted in the same cycle as upd_valid SHALL discard the update.
REQ-024 The first update SHALL be accepted on the first rising clk after rst deasserts.

Configuration
REQ-025 With macro BRANCH_PRED_EN defined, SHALL implement the table and behaviour above.
REQ-026 With BRANCH_PRED_EN undefined, SHALL contain no table storage, tie pre_branch1/2 = 0 and predict_pc1/2 = 0, and ignore upd_*; the port list SHALL be unchanged.

Verification
REQ-027 Reset, then pc1 = 0x100, pc2 = 0x104 -> pre_branch1 = pre_branch2 = 0, predict_pc1 = predict_pc2 = 0.
REQ-028 Update upd_pc = 0x104, taken, target 0x200; next cycle pc1 = 0x100, pc2 = 0x104 -> pre_branch2 = 1, predict_pc2 = 0x200, pre_branch1 = 0.
REQ-029 After REQ-028, one not-taken update of 0x104 -> counter = 01, pre_branch2 = 0; a second not-taken update -> counter = 00; then two taken updates -> counter = 10, pre_branch2 = 1.
REQ-030 Entry 0x104 is valid; update 0x144 taken with target 0x300 (IDX_W = 4, same index, new tag) -> lookup of 0x104 misses and lookup of 0x144 gives 0x300.
REQ-031 Update 0x108 taken with pc1 = 0x108 in the same cycle -> pre_branch1 = 0 that cycle and 1 the next cycle; rst pulsed low mid-run -> all predictions are 0 afterwards.
REQ-032 Build without BRANCH_PRED_EN and repeat REQ-028 -> outputs remain 0.
